// File: rtl/mux_2_4_select_unit_pkg.sv
// -----------------------------------------------------------------------------
// mux_2_4_select_unit_pkg
// Shared constants and helpers for the 2:1 / 4:1 bit-sliced selection unit.
//   MUX_LANES2 : number of lanes on the 2:1 path
//   MUX_LANES4 : number of lanes on the 4:1 path
//   lane_base  : bit offset of lane k inside a packed lane bus of given width
// -----------------------------------------------------------------------------
package mux_2_4_select_unit_pkg;

    localparam int MUX_LANES2 = 2;
    localparam int MUX_LANES4 = 4;

    // Lane k occupies bus[lane_base(k, width) +: width].
    function automatic int lane_base(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/mux_2_4_select_unit_mux2_cell.sv
// -----------------------------------------------------------------------------
// mux2_cell
// WIDTH-bit combinational 2:1 selector; leaf cell of both selection paths.
// Ports:
//   a   : input  [WIDTH-1:0]  selected when sel = 0
//   b   : input  [WIDTH-1:0]  selected when sel = 1
//   sel : input               select
//   y   : output [WIDTH-1:0]  selected data
// -----------------------------------------------------------------------------
module mux2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Whole-vector select keeps every output bit a function of the same bit
    // of a and b only.
    assign y = sel ? b : a;

endmodule

// File: rtl/mux_2_4_select_unit.sv
// -----------------------------------------------------------------------------
// mux_2_4_select_unit
// Two independent bit-sliced selection paths (2:1 and 4:1), each WIDTH bits,
// with an optional output register sharing clk / reset / en.
// Parameters:
//   WIDTH   : bits per lane and per output
//   REG_OUT : 1 = registered outputs (1-cycle latency), 0 = combinational
// Ports:
//   clk   : input                rising-edge clock (REG_OUT=1 only)
//   reset : input                async active-high reset, clears outputs
//   en    : input                capture enable for the output registers
//   in2   : input  [2*WIDTH-1:0] 2:1 lanes, lane k = in2[k*WIDTH +: WIDTH]
//   sel2  : input                2:1 select
//   out2  : output [WIDTH-1:0]   2:1 result
//   in4   : input  [4*WIDTH-1:0] 4:1 lanes, lane k = in4[k*WIDTH +: WIDTH]
//   sel4  : input  [1:0]         4:1 select, unsigned binary
//   out4  : output [WIDTH-1:0]   4:1 result
// -----------------------------------------------------------------------------
module mux_2_4_select_unit
    import mux_2_4_select_unit_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [MUX_LANES2*WIDTH-1:0] in2,
    input  logic                      sel2,
    output logic [WIDTH-1:0]          out2,
    input  logic [MUX_LANES4*WIDTH-1:0] in4,
    input  logic [1:0]                sel4,
    output logic [WIDTH-1:0]          out4
);

    // ---------------------------------------------------------------------
    // Lane unpacking
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] w_lane2 [MUX_LANES2];
    logic [WIDTH-1:0] w_lane4 [MUX_LANES4];

    for (genvar k = 0; k < MUX_LANES2; k++) begin : g_lane2
        assign w_lane2[k] = in2[lane_base(k, WIDTH) +: WIDTH];
    end

    for (genvar k = 0; k < MUX_LANES4; k++) begin : g_lane4
        assign w_lane4[k] = in4[lane_base(k, WIDTH) +: WIDTH];
    end

    // ---------------------------------------------------------------------
    // Combinational selection
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] w_out2_c;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_out4_c;

    mux2_cell #(.WIDTH(WIDTH)) u_cell_2 (
        .a   (w_lane2[0]),
        .b   (w_lane2[1]),
        .sel (sel2),
        .y   (w_out2_c)
    );

    // 4:1 tree: low bit of the select picks within each pair, high bit picks
    // the pair. Equivalent to direct indexing for every code.
    mux2_cell #(.WIDTH(WIDTH)) u_cell_a (
        .a   (w_lane4[0]),
        .b   (w_lane4[1]),
        .sel (sel4[0]),
        .y   (w_sel_a)
    );

    mux2_cell #(.WIDTH(WIDTH)) u_cell_b (
        .a   (w_lane4[2]),
        .b   (w_lane4[3]),
        .sel (sel4[0]),
        .y   (w_sel_b)
    );

    mux2_cell #(.WIDTH(WIDTH)) u_cell_c (
        .a   (w_sel_a),
        .b   (w_sel_b),
        .sel (sel4[1]),
        .y   (w_out4_c)
    );

    // ---------------------------------------------------------------------
    // Optional output register
    // ---------------------------------------------------------------------
    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] r_out2;
        logic [WIDTH-1:0] r_out4;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_out2 <= '0;
                r_out4 <= '0;
            end else if (en) begin
                r_out2 <= w_out2_c;
                r_out4 <= w_out4_c;
            end
        end

        assign out2 = r_out2;
        assign out4 = r_out4;
    end else begin : g_comb
        // Control inputs have no function in the purely combinational build.
        logic w_unused_ctrl;
        assign w_unused_ctrl = ^{clk, reset, en};

        assign out2 = w_out2_c;
        assign out4 = w_out4_c;
    end

endmodule

// File: tb/tb_mux_2_4_select_unit.sv
// -----------------------------------------------------------------------------
// tb_mux_2_4_select_unit
// Self-checking bench for mux_2_4_select_unit. Three instances:
//   u_reg1 : WIDTH=1, REG_OUT=1
//   u_reg8 : WIDTH=8, REG_OUT=1
//   u_comb : WIDTH=1, REG_OUT=0
// Registered results are predicted when stimulus is driven, queued, and
// compared after the capturing edge.
// -----------------------------------------------------------------------------
module tb_mux_2_4_select_unit;

    logic clk = 1'b0;
    logic reset;
    logic en;

    always #5 clk = ~clk;

    // WIDTH=1 registered instance
    logic [1:0] a_in2;
    logic       a_sel2;
    logic       a_out2;
    logic [3:0] a_in4;
    logic [1:0] a_sel4;
    logic       a_out4;

    // WIDTH=8 registered instance
    logic [15:0] b_in2;
    logic        b_sel2;
    logic [7:0]  b_out2;
    logic [31:0] b_in4;
    logic [1:0]  b_sel4;
    logic [7:0]  b_out4;

    // WIDTH=1 combinational instance
    logic [1:0] c_in2;
    logic       c_sel2;
    logic       c_out2;
    logic [3:0] c_in4;
    logic [1:0] c_sel4;
    logic       c_out4;

    mux_2_4_select_unit #(.WIDTH(1), .REG_OUT(1)) u_reg1 (
        .clk (clk), .reset (reset), .en (en),
        .in2 (a_in2), .sel2 (a_sel2), .out2 (a_out2),
        .in4 (a_in4), .sel4 (a_sel4), .out4 (a_out4)
    );

    mux_2_4_select_unit #(.WIDTH(8), .REG_OUT(1)) u_reg8 (
        .clk (clk), .reset (reset), .en (en),
        .in2 (b_in2), .sel2 (b_sel2), .out2 (b_out2),
        .in4 (b_in4), .sel4 (b_sel4), .out4 (b_out4)
    );

    mux_2_4_select_unit #(.WIDTH(1), .REG_OUT(0)) u_comb (
        .clk (clk), .reset (reset), .en (en),
        .in2 (c_in2), .sel2 (c_sel2), .out2 (c_out2),
        .in4 (c_in4), .sel4 (c_sel4), .out4 (c_out4)
    );

    // ---------------------------------------------------------------------
    // Checking and scoreboard
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    typedef struct {
        string      tag;
        logic [7:0] e2;
        logic [7:0] e4;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];

    // Reference: lane idx of a packed lane bus of the given width.
    function automatic logic [7:0] lane_of(input logic [31:0] bus, input int idx,
                                           input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return 8'((bus >> (idx * width)) & mask);
    endfunction

    task automatic push1(input string tag);
        exp_t e;
        e.tag = tag;
        e.e2  = lane_of(32'(a_in2), int'(a_sel2), 1);
        e.e4  = lane_of(32'(a_in4), int'(a_sel4), 1);
        q1.push_back(e);
    endtask

    task automatic push8(input string tag);
        exp_t e;
        e.tag = tag;
        e.e2  = lane_of(32'(b_in2), int'(b_sel2), 8);
        e.e4  = lane_of(b_in4, int'(b_sel4), 8);
        q8.push_back(e);
    endtask

    task automatic pop_check1();
        exp_t e;
        if (q1.size() == 0) begin
            check("sb1_underflow", 32'(q1.size()), 32'd1);
        end else begin
            e = q1.pop_front();
            check({e.tag, "_out2"}, 32'(a_out2), 32'(e.e2[0]));
            check({e.tag, "_out4"}, 32'(a_out4), 32'(e.e4[0]));
        end
    endtask

    task automatic pop_check8();
        exp_t e;
        if (q8.size() == 0) begin
            check("sb8_underflow", 32'(q8.size()), 32'd1);
        end else begin
            e = q8.pop_front();
            check({e.tag, "_out2"}, 32'(b_out2), 32'(e.e2));
            check({e.tag, "_out4"}, 32'(b_out4), 32'(e.e4));
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic prev2;
        logic prev4;
        logic [3:0] v4;
        logic [1:0] v2;

        reset = 1'b1;
        en    = 1'b0;
        a_in2 = '0; a_sel2 = '0; a_in4 = '0; a_sel4 = '0;
        b_in2 = '0; b_sel2 = '0; b_in4 = '0; b_sel4 = '0;
        c_in2 = '0; c_sel2 = '0; c_in4 = '0; c_sel4 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out2", 32'(a_out2), 32'd0);
        check("rst_a_out4", 32'(a_out4), 32'd0);
        check("rst_b_out2", 32'(b_out2), 32'd0);
        check("rst_b_out4", 32'(b_out4), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;

        // Walking one on both paths at once: 4 combos on the 2:1 path and
        // all 16 sel4 x one-hot combos on the 4:1 path.
        prev2 = 1'b0;
        prev4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_sel4 = 2'(i / 4);
            a_in4  = 4'(1 << (i % 4));
            a_sel2 = 1'((i >> 1) & 1);
            a_in2  = 2'(1 << (i & 1));
            push1($sformatf("walk%0d", i));
            #1;
            // Registered outputs must not react before the capturing edge.
            check($sformatf("walk%0d_hold2", i), 32'(a_out2), 32'(prev2));
            check($sformatf("walk%0d_hold4", i), 32'(a_out4), 32'(prev4));
            prev2 = a_in2[a_sel2];
            prev4 = a_in4[a_sel4];
            @(posedge clk);
            #1;
            pop_check1();
        end

        // Asynchronous reset mid-cycle
        @(negedge clk);
        a_in2 = 2'b11; a_in4 = 4'hF; a_sel2 = 1'b0; a_sel4 = 2'd0;
        push1("load_ones");
        @(posedge clk);
        #1;
        pop_check1();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out2", 32'(a_out2), 32'd0);
        check("async_rst_out4", 32'(a_out4), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d_out2", i), 32'(a_out2), 32'd0);
            check($sformatf("rst_hold%0d_out4", i), 32'(a_out4), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        push1("first_after_rst");
        @(posedge clk);
        #1;
        pop_check1();

        // Wide lanes
        @(negedge clk);
        b_in4  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        b_sel4 = 2'd2;
        b_in2  = {8'h5A, 8'hA5};
        b_sel2 = 1'b1;
        push8("wide");
        @(posedge clk);
        #1;
        check("wide_out4_cc", 32'(b_out4), 32'hCC);
        pop_check8();

        // Enable hold
        @(negedge clk);
        en     = 1'b0;
        b_sel4 = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("en_hold%0d_out4", i), 32'(b_out4), 32'hCC);
            check($sformatf("en_hold%0d_out2", i), 32'(b_out2), 32'h5A);
        end
        @(negedge clk);
        en = 1'b1;
        push8("en_resume");
        @(posedge clk);
        #1;
        check("en_resume_out4_aa", 32'(b_out4), 32'hAA);
        pop_check8();

        // Random wide traffic, both paths changing together
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b_in4  = $urandom;
            b_sel4 = 2'($urandom_range(3));
            b_in2  = 16'($urandom);
            b_sel2 = 1'($urandom_range(1));
            push8($sformatf("rand%0d", i));
            @(posedge clk);
            #1;
            pop_check8();
        end

        // Combinational instance: exhaustive sweeps, control lines toggling
        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < 16; v++) begin
                v4     = 4'(v);
                c_sel4 = 2'(s);
                c_in4  = v4;
                reset  = 1'($urandom_range(1));
                en     = 1'($urandom_range(1));
                #1;
                check($sformatf("comb4_s%0d_v%0h", s, v), 32'(c_out4), 32'(v4[s]));
            end
        end
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 4; v++) begin
                v2     = 2'(v);
                c_sel2 = 1'(s);
                c_in2  = v2;
                reset  = 1'($urandom_range(1));
                en     = 1'($urandom_range(1));
                #1;
                check($sformatf("comb2_s%0d_v%0h", s, v), 32'(c_out2), 32'(v2[s]));
            end
        end

        check("sb1_drained", 32'(q1.size()), 32'd0);
        check("sb8_drained", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mux_2_4_select_unit.md
Name: mux_2_4_select_unit

Overview:
- Bit-sliced selection block providing two independent paths: a 2:1 path and a 4:1 path, each WIDTH bits wide.
- Used as the leaf building block for wider selector trees. Two 4:1 paths plus a 2:1 path form an 8:1 selector.
- Each path has an optional output register in the single clock domain. The register uses an asynchronous, active-high reset.

Parameters:
- WIDTH, 1, bits per input lane and per output.
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational (clk/reset/en ignored).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; clears registered outputs.
- en  input  1  capture enable for output registers (REG_OUT=1 only).
- in2  input  2*WIDTH  2:1 path data; lane k = in2[k*WIDTH +: WIDTH], k=0..1.
- sel2  input  1  2:1 path select.
- out2  output  WIDTH  2:1 path result.
- in4  input  4*WIDTH  4:1 path data; lane k = in4[k*WIDTH +: WIDTH], k=0..3.
- sel4  input  2  4:1 path select, unsigned binary.
- out4  output  WIDTH  4:1 path result.

Behaviour:
- Select functions:
  - Combinational 2:1 result = lane sel2 of in2 (sel2=0 gives lane 0, sel2=1 gives lane 1).
  - Combinational 4:1 result = lane sel4 of in4.
  - All select codes are valid; there is no default or illegal code.
- 4:1 structure: built from three 2:1 cells.
  - Cell A selects lane 0/1 on sel4[0].
  - Cell B selects lane 2/3 on sel4[0].
  - Cell C selects A/B on sel4[1].
  - Result is bit-identical to direct indexing for every code.
- Bit independence: bit j of each output depends only on bit j of each lane and the select.
- REG_OUT=0:
  - out2 and out4 follow inputs combinationally, with zero cycles of latency.
  - No state is held; clk, reset and en have no effect.
- REG_OUT=1:
  - reset high forces out2=0 and out4=0 immediately, with no clock needed, and holds them there while asserted.
  - On a rising clk edge with reset low and en=1, both outputs capture their combinational results.
  - On a rising clk edge with en=0, both outputs hold.
  - Latency is exactly 1 cycle from input/select change to output.
  - reset deasserting: the first capture occurs on the first rising edge with reset low and en=1.
  - Reset asserted mid-stream discards pending data; there is no recovery of the prior value.
  - Inputs and select changing on the same edge as capture: the pre-edge values are captured.
- Both paths share clk, reset and en but are otherwise fully independent. Simultaneous changes on both paths must not interact.
- No handshake; no FSM.

Decomposition:
- Shared package: a MUX_LANES2 = 2 constant, a MUX_LANES4 = 4 constant, and a lane-index helper function (base offset = k*WIDTH). Parameter-free typedefs are not required.
- One sub-module: mux2_cell, a WIDTH-parameterised combinational 2:1 selector with inputs a, b, sel and output y.
  - Instanced once for the 2:1 path.
  - Instanced three times for the 4:1 path.
- Output registers live in the top level, under a generate on REG_OUT.

Test Plan:
- Reset: REG_OUT=1, WIDTH=1, in2=2'b11, in4=4'hF, assert reset mid-cycle -> out2=0 and out4=0 before the next edge; both remain 0 while reset=1 despite clocks with en=1.
- Walking one, 2:1: WIDTH=1, en=1. For sel2=0,1, set in2=2'b01 then 2'b10 -> out2=1 only when the set bit index equals sel2, one cycle after the change; otherwise 0.
- Walking one, 4:1: WIDTH=1, en=1. For each sel4=0..3, step in4 through 4'b0001, 0010, 0100, 1000 -> out4=1 only when the one-hot position equals sel4; all 16 combinations checked.
- Wide lanes: WIDTH=8, in4={8'hDD,8'hCC,8'hBB,8'hAA}, sel4=2 -> out4=8'hCC after one edge. in2={8'h5A,8'hA5}, sel2=1 -> out2=8'h5A.
- Enable hold: after capturing out4=8'hCC, set en=0 and change sel4=0 -> out4 stays 8'hCC over 3 edges; re-assert en=1 -> out4=8'hAA after 1 edge.
- Combinational mode: REG_OUT=0, WIDTH=1, exhaustive sweep of sel4 x in4 (64 cases) and sel2 x in2 (8 cases) -> outputs equal direct lane indexing with no clock; reset and en toggling have no effect.
